// File: rtl/pipeline_fetch_pkg.sv
// pipeline_fetch_pkg: pc-select codes shared with pipeline_control, reset pc and fetch queue entry type.
package pipeline_fetch_pkg;
  localparam logic [31:0] DEFAULT_INITIAL_PC = 32'h0040_0000;
  localparam logic [1:0] CTL_PC_PC4 = 2'd0;
  localparam logic [1:0] CTL_PC_PC_IMM = 2'd1;
  localparam logic [1:0] CTL_PC_RS1_IMM = 2'd2;
  localparam logic [1:0] CTL_PC_PC4_BR = 2'd3;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
  function automatic logic [31:0] redirect_target(input logic [1:0] sel, input logic [31:0] pc,
                                                  input logic [31:0] imm, input logic [31:0] rs1);
    return sel == CTL_PC_PC_IMM ? pc + imm :
           sel == CTL_PC_RS1_IMM ? (rs1 + imm) & ~32'h1 : pc + 32'd4;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous {pc,inst} FIFO with push/pop and a flush that wins over both.
module fetch_queue
  import pipeline_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      rd <= rd + AW'(pop);
      wr <= wr + AW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clock)
    if (push && !flush) mem[wr] <= push_data;
  assign head = mem[rd];
endmodule

// File: rtl/pipeline_fetch.sv
// pipeline_fetch: fetch pc, in-order imem requests, response queue to decode, redirect with wrong-path drop.
module pipeline_fetch
  import pipeline_fetch_pkg::*;
#(
  parameter logic [31:0] INITIAL_PC = DEFAULT_INITIAL_PC,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [1:0]  next_pc_select,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_inst
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  logic [31:0] pc, resp_pc;
  logic [CW-1:0] inflight, drop, count;
  logic [CW:0] occ;
  logic redirect, accept, resp_live, pop;
  fetch_entry_t head, push_entry;
  assign redirect = ex_valid && next_pc_select != CTL_PC_PC4;
  assign occ = {1'b0, inflight} + {1'b0, count};
  assign imem_req_valid = reset && !redirect && occ < (CW+1)'(QUEUE_DEPTH);
  assign imem_req_addr = pc;
  assign accept = imem_req_valid && imem_req_ready;
  assign resp_live = imem_resp_valid && drop == '0 && !redirect;
  assign pop = fetch_valid && fetch_ready && !redirect;
  // live requests since the last redirect are sequential and end at pc-4, so the oldest one's pc is derived
  assign resp_pc = pc - (32'(inflight - drop) << 2);
  assign push_entry = '{pc: resp_pc, inst: imem_resp_data};
  assign fetch_valid = count != '0;
  assign fetch_pc = head.pc;
  assign fetch_inst = head.inst;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pc <= INITIAL_PC;
      inflight <= '0;
      drop <= '0;
    end else begin
      pc <= redirect ? redirect_target(next_pc_select, ex_pc, ex_imm, ex_rs1) : accept ? pc + 32'd4 : pc;
      inflight <= inflight + CW'(accept) - CW'(imem_resp_valid);
      drop <= redirect ? inflight - CW'(imem_resp_valid) : drop - CW'(imem_resp_valid && drop != '0);
    end
  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clock(clock), .reset(reset), .push(resp_live), .pop(pop), .flush(redirect),
    .push_data(push_entry), .count(count), .head(head)
  );
  a_occ: assert property (@(posedge clock) disable iff (!reset) occ <= (CW+1)'(QUEUE_DEPTH));
  a_push_full: assert property (@(posedge clock) disable iff (!reset) !(resp_live && count == CW'(QUEUE_DEPTH)));
  a_drop: assert property (@(posedge clock) disable iff (!reset) drop <= inflight);
  a_resp_underflow: assert property (@(posedge clock) disable iff (!reset) !(imem_resp_valid && inflight == '0));
endmodule

// File: tb/tb_pipeline_fetch.sv
// tb_pipeline_fetch: memory model plus {pc,inst} scoreboard for the fetch stage.
module tb_pipeline_fetch;
  import pipeline_fetch_pkg::*;
  logic clock = 0, reset = 0;
  logic ex_valid = 0, imem_req_ready = 1, imem_resp_valid = 0, fetch_ready = 1;
  logic [1:0] next_pc_select = CTL_PC_PC4;
  logic [31:0] ex_pc = 0, ex_imm = 0, ex_rs1 = 0, imem_resp_data = 0;
  logic imem_req_valid, fetch_valid;
  logic [31:0] imem_req_addr, fetch_pc, fetch_inst;
  always #5 clock = ~clock;
  pipeline_fetch dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .next_pc_select(next_pc_select),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst)
  );
  typedef struct {
    logic [31:0] addr;
    int acc;
    bit live;
  } mreq_t;
  mreq_t mq[$];
  logic [63:0] exp_q[$];
  logic [31:0] mpc, rd_want, saved;
  int checks = 0, errors = 0, cyc = 0, lat = 1;
  bit found;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction
  function automatic bit resp_due();
    if (mq.size() == 0) return 0;
    return cyc - mq[0].acc >= lat;
  endfunction
  task automatic step();
    int live, queued;
    bit rdir, acc, pop;
    #1;
    live = 0;
    foreach (mq[i]) if (mq[i].live) live++;
    queued = exp_q.size() - live;
    rdir = ex_valid && next_pc_select != CTL_PC_PC4;
    check("req_valid", imem_req_valid, !rdir && (mq.size() + queued < 2));
    if (imem_req_valid) check("req_addr", imem_req_addr, mpc);
    check("fetch_valid", fetch_valid, queued > 0);
    if (fetch_valid && queued > 0) check("fetch_head", {fetch_pc, fetch_inst}, exp_q[0]);
    acc = imem_req_valid && imem_req_ready;
    pop = fetch_valid && fetch_ready;
    imem_resp_valid = 0;
    imem_resp_data = 0;
    if (resp_due()) begin
      imem_resp_valid = 1;
      imem_resp_data = inst_of(mq[0].addr);
      void'(mq.pop_front());
    end
    if (rdir) begin
      exp_q.delete();
      foreach (mq[i]) mq[i].live = 0;
    end else if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) mq.push_back('{imem_req_addr, cyc, !rdir});
    if (acc && !rdir) begin
      exp_q.push_back({mpc, inst_of(mpc)});
      mpc += 32'd4;
    end
    if (rdir) mpc = rd_want;
    cyc++;
    @(negedge clock);
  endtask
  task automatic redirect(input logic [1:0] sel, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] rs1, input logic [31:0] want);
    ex_valid = 1;
    next_pc_select = sel;
    ex_pc = pc;
    ex_imm = imm;
    ex_rs1 = rs1;
    rd_want = want;
    step();
    ex_valid = 0;
    next_pc_select = CTL_PC_PC4;
  endtask
  task automatic do_reset();
    reset = 0;
    ex_valid = 0;
    imem_resp_valid = 0;
    mq.delete();
    exp_q.delete();
    mpc = 32'h0040_0000;
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_fetch_valid", fetch_valid, 0);
    @(negedge clock);
    @(negedge clock);
    check("rst_addr", imem_req_addr, 32'h0040_0000);
    reset = 1;
    #1;
    check("release_addr", imem_req_addr, 32'h0040_0000);
  endtask
  initial begin
    @(negedge clock);
    do_reset();
    repeat (12) step();
    do_reset();
    fetch_ready = 0;
    repeat (6) step();
    check("hold_pc", fetch_pc, 32'h0040_0000);
    check("hold_inst", fetch_inst, inst_of(32'h0040_0000));
    fetch_ready = 1;
    repeat (6) step();
    imem_req_ready = 0;
    saved = imem_req_addr;
    repeat (3) step();
    check("stall_addr", imem_req_addr, saved);
    imem_req_ready = 1;
    repeat (5) step();
    do_reset();
    lat = 3;
    step();
    step();
    check("two_inflight", mq.size(), 2);
    redirect(CTL_PC_PC_IMM, 32'h0040_0010, 32'h20, 0, 32'h0040_0030);
    check("redir_addr", imem_req_addr, 32'h0040_0030);
    repeat (8) step();
    redirect(CTL_PC_PC4_BR, 32'h0040_0100, 0, 0, 32'h0040_0104);
    redirect(CTL_PC_PC_IMM, 32'h0040_0200, 32'h8, 0, 32'h0040_0208);
    repeat (8) step();
    lat = 1;
    repeat (4) step();
    redirect(CTL_PC_RS1_IMM, 0, 32'h2, 32'h0040_0101, 32'h0040_0102);
    check("rs1_addr", imem_req_addr, 32'h0040_0102);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      #1;
      if (fetch_valid && resp_due()) found = 1;
      else step();
    end
    check("resp_pop_setup", found, 1);
    redirect(CTL_PC_PC4_BR, 32'h0040_0300, 0, 0, 32'h0040_0304);
    check("flushed_empty", fetch_valid, 0);
    repeat (6) step();
    redirect(CTL_PC_PC_IMM, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC);
    check("wrap_start", imem_req_addr, 32'hFFFF_FFFC);
    repeat (8) step();
    check("wrap_done", imem_req_addr < 32'h100, 1);
    do_reset();
    repeat (8) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
